// File: rtl/fetch_queue_riscv_if.sv
// Fetch-stage bus: instruction-memory port, decode-side valid/ready port and redirect inputs.
// master = fetch queue side, slave = environment (imem, decode, execute) side.
interface fetch_queue_riscv_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned DEPTH = 4
);
    logic                       branch_en;
    logic [XLEN-1:0]            branch_pc;
    logic [XLEN-1:0]            imem_addr;
    logic                       imem_en;
    logic [ILEN-1:0]            imem_rdata;
    logic                       out_valid;
    logic                       out_ready;
    logic [XLEN-1:0]            out_pc;
    logic [ILEN-1:0]            out_instr;
    logic [$clog2(DEPTH):0]     count;
    logic                       misalign_err;

    modport master (
        input  branch_en, branch_pc, imem_rdata, out_ready,
        output imem_addr, imem_en, out_valid, out_pc, out_instr, count, misalign_err
    );

    modport slave (
        output branch_en, branch_pc, imem_rdata, out_ready,
        input  imem_addr, imem_en, out_valid, out_pc, out_instr, count, misalign_err
    );
endinterface

// File: rtl/fetch_queue_riscv.sv
// Fetch stage: owns the PC, fetches whenever the queue has room and buffers {pc, instr}
// pairs for decode. A redirect flushes the queue and restarts fetch at the target.
module fetch_queue_riscv #(
    parameter int unsigned    XLEN     = 64,
    parameter int unsigned    ILEN     = 32,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_queue_riscv_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [ILEN-1:0] mem_instr [DEPTH];

    logic push;
    logic pop;
    logic out_valid;

    // Push depends only on registered occupancy, so out_ready never reaches imem_en.
    assign push      = rst_n & ~bus.branch_en & (count_q < DepthC);
    assign out_valid = (count_q != '0) & ~bus.branch_en;
    assign pop       = out_valid & bus.out_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        misalign_d = 1'b0;
        if (bus.branch_en) begin
            fetch_pc_d = {bus.branch_pc[XLEN-1:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            misalign_d = |bus.branch_pc[1:0];
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PW'(1);
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Storage is deliberately unreset; contents only matter while out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr_q]    <= fetch_pc_q;
            mem_instr[wr_ptr_q] <= bus.imem_rdata;
        end
    end

    assign bus.imem_addr    = fetch_pc_q;
    assign bus.imem_en      = push;
    assign bus.out_valid    = out_valid;
    assign bus.out_pc       = mem_pc[rd_ptr_q];
    assign bus.out_instr    = mem_instr[rd_ptr_q];
    assign bus.count        = count_q;
    assign bus.misalign_err = misalign_q;
endmodule

// File: tb/tb_fetch_queue_riscv.sv
// Directed bench for fetch_queue_riscv: one instance at RESET_PC=0, a second at RESET_PC=0x80
// used for the mid-stream reset scenario.
module tb_fetch_queue_riscv;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_cmp;
    int   n_err;

    fetch_queue_riscv_if #(.XLEN(64), .ILEN(32), .DEPTH(4)) bus_a ();
    fetch_queue_riscv_if #(.XLEN(64), .ILEN(32), .DEPTH(4)) bus_b ();

    fetch_queue_riscv #(.XLEN(64), .ILEN(32), .DEPTH(4), .RESET_PC(64'h0)) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (bus_a)
    );

    fetch_queue_riscv #(.XLEN(64), .ILEN(32), .DEPTH(4), .RESET_PC(64'h80)) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (bus_b)
    );

    function automatic logic [31:0] instr_of(input logic [63:0] addr);
        return addr[31:0] ^ 32'h1357_9BDF;
    endfunction

    assign bus_a.imem_rdata = instr_of(bus_a.imem_addr);
    assign bus_b.imem_rdata = instr_of(bus_b.imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_a.branch_en = 1'b0;
        bus_a.branch_pc = '0;
        bus_b.out_ready = 1'b1;
        bus_b.branch_en = 1'b0;
        bus_b.branch_pc = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_count", 64'(bus_a.count), 64'd0);
        chk("rst_valid", 64'(bus_a.out_valid), 64'd0);
        chk("rst_imem_en", 64'(bus_a.imem_en), 64'd0);
        chk("rst_misalign", 64'(bus_a.misalign_err), 64'd0);

        // 1: streaming with out_ready=1
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        chk("t1_imem_en", 64'(bus_a.imem_en), 64'd1);
        chk("t1_addr0", bus_a.imem_addr, 64'h0);
        chk("t1_valid0", 64'(bus_a.out_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_valid", 64'(bus_a.out_valid), 64'd1);
            chk("t1_pc", bus_a.out_pc, 64'(4 * i));
            chk("t1_instr", 64'(bus_a.out_instr), 64'(instr_of(64'(4 * i))));
            chk("t1_count", 64'(bus_a.count), 64'd1);
        end

        // 2: backpressure fills the queue, then drains in order
        rst_a = 1'b0;
        bus_a.out_ready = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        repeat (10) tick();
        chk("t2_count_full", 64'(bus_a.count), 64'd4);
        chk("t2_imem_en_full", 64'(bus_a.imem_en), 64'd0);
        chk("t2_head_pc", bus_a.out_pc, 64'h0);
        chk("t2_head_instr", 64'(bus_a.out_instr), 64'(instr_of(64'h0)));
        bus_a.out_ready = 1'b1;
        #1;
        chk("t2_imem_en_pop", 64'(bus_a.imem_en), 64'd0);
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid", 64'(bus_a.out_valid), 64'd1);
            chk("t2_pc", bus_a.out_pc, 64'(4 * i));
            if (i < 4) tick();
        end
        chk("t2_count_drain", 64'(bus_a.count), 64'd3);

        // 3: flush a full queue holding 0x10..0x1C
        bus_a.out_ready = 1'b0;
        tick();
        chk("t3_count_full", 64'(bus_a.count), 64'd4);
        chk("t3_head", bus_a.out_pc, 64'h10);
        bus_a.branch_en = 1'b1;
        bus_a.branch_pc = 64'h100;
        #1;
        chk("t3_valid_br", 64'(bus_a.out_valid), 64'd0);
        chk("t3_imem_en_br", 64'(bus_a.imem_en), 64'd0);
        tick();
        bus_a.branch_en = 1'b0;
        bus_a.out_ready = 1'b1;
        #1;
        chk("t3_count_flush", 64'(bus_a.count), 64'd0);
        chk("t3_valid_flush", 64'(bus_a.out_valid), 64'd0);
        chk("t3_addr", bus_a.imem_addr, 64'h100);
        chk("t3_misalign", 64'(bus_a.misalign_err), 64'd0);
        tick();
        chk("t3_valid_tgt", 64'(bus_a.out_valid), 64'd1);
        chk("t3_pc_tgt", bus_a.out_pc, 64'h100);
        chk("t3_instr_tgt", 64'(bus_a.out_instr), 64'(instr_of(64'h100)));

        // 4: misaligned target
        bus_a.branch_en = 1'b1;
        bus_a.branch_pc = 64'h102;
        tick();
        bus_a.branch_en = 1'b0;
        #1;
        chk("t4_misalign_hi", 64'(bus_a.misalign_err), 64'd1);
        chk("t4_addr", bus_a.imem_addr, 64'h100);
        chk("t4_count", 64'(bus_a.count), 64'd0);
        tick();
        chk("t4_misalign_lo", 64'(bus_a.misalign_err), 64'd0);
        chk("t4_pc", bus_a.out_pc, 64'h100);

        // 5: redirect coincides with out_ready and count=3
        bus_a.out_ready = 1'b0;
        repeat (2) tick();
        chk("t5_count3", 64'(bus_a.count), 64'd3);
        bus_a.out_ready = 1'b1;
        bus_a.branch_en = 1'b1;
        bus_a.branch_pc = 64'h200;
        #1;
        chk("t5_valid_br", 64'(bus_a.out_valid), 64'd0);
        tick();
        bus_a.branch_en = 1'b0;
        #1;
        chk("t5_count0", 64'(bus_a.count), 64'd0);
        chk("t5_valid0", 64'(bus_a.out_valid), 64'd0);
        tick();
        chk("t5_pc_tgt", bus_a.out_pc, 64'h200);
        chk("t5_instr_tgt", 64'(bus_a.out_instr), 64'(instr_of(64'h200)));

        // PC wraps modulo 2^64
        bus_a.branch_en = 1'b1;
        bus_a.branch_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        bus_a.branch_en = 1'b0;
        tick();
        chk("wrap_top", bus_a.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_zero", bus_a.out_pc, 64'h0);

        // 6: asynchronous reset mid-stream on the RESET_PC=0x80 instance
        chk("t6_pre_count", 64'(bus_b.count), 64'd1);
        chk("t6_pre_valid", 64'(bus_b.out_valid), 64'd1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("t6_count", 64'(bus_b.count), 64'd0);
        chk("t6_valid", 64'(bus_b.out_valid), 64'd0);
        chk("t6_imem_en", 64'(bus_b.imem_en), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("t6_addr", bus_b.imem_addr, 64'h80);
        chk("t6_imem_en_rel", 64'(bus_b.imem_en), 64'd1);
        tick();
        chk("t6_pc0", bus_b.out_pc, 64'h80);
        chk("t6_instr0", 64'(bus_b.out_instr), 64'(instr_of(64'h80)));
        tick();
        chk("t6_pc1", bus_b.out_pc, 64'h84);
        chk("t6_count1", 64'(bus_b.count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
